// File: rtl/uart_loopback_checker_if.sv
`timescale 1ns/1ps
// uart_loopback_checker_if
// Host-side control/status bundle of the UART loopback checker.
// The host (master) issues start/cont/seed; the checker (slave) reports
// progress and running pass/error counts.
// Build macro UART_LBCHK_INJECT_EN adds the inject_err control.
interface uart_loopback_checker_if #(
    parameter int DBIT = 8
);
    logic            start;
    logic            cont;
    logic [DBIT-1:0] seed;
`ifdef UART_LBCHK_INJECT_EN
    logic            inject_err;
`endif
    logic            busy;
    logic            done_tick;
    logic [DBIT-1:0] last_sent;
    logic [DBIT-1:0] last_rcvd;
    logic [15:0]     pass_cnt;
    logic [15:0]     err_cnt;

`ifdef UART_LBCHK_INJECT_EN
    modport master (output start, cont, seed, inject_err,
                    input  busy, done_tick, last_sent, last_rcvd, pass_cnt, err_cnt);
    modport slave  (input  start, cont, seed, inject_err,
                    output busy, done_tick, last_sent, last_rcvd, pass_cnt, err_cnt);
`else
    modport master (output start, cont, seed,
                    input  busy, done_tick, last_sent, last_rcvd, pass_cnt, err_cnt);
    modport slave  (input  start, cont, seed,
                    output busy, done_tick, last_sent, last_rcvd, pass_cnt, err_cnt);
`endif
endinterface

// File: rtl/uart_loopback_checker.sv
`timescale 1ns/1ps
// uart_loopback_checker
// Far end of a UART loopback link: serialises a byte onto tx, deserialises
// the reply on rx and checks reply == sent+1, counting passes and errors
// (mismatch, framing error, reply timeout). Continuous mode steps the byte
// after every check until reset.
// Build macro UART_LBCHK_INJECT_EN: inverts bit 0 of the transmitted byte
// when host.inject_err is high as SEND is entered.
module uart_loopback_checker #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int DVSR       = 163,
    parameter int TIMEOUT_BT = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  tx,
    uart_loopback_checker_if.slave host
);
    localparam int BW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int SW = $clog2((SB_TICK > 16) ? SB_TICK : 16);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int TW = (TIMEOUT_BT > 1) ? $clog2(TIMEOUT_BT) : 1;

    typedef enum logic [1:0] {C_IDLE, C_SEND, C_WAIT, C_CHECK} ctrl_e;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_e;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_e;

    logic [BW-1:0]   baud_q, baud_d;
    logic            tick;
    ctrl_e           ctrl_q, ctrl_d;
    logic [DBIT-1:0] send_q, send_d, last_sent_q, last_sent_d, last_rcvd_q, last_rcvd_d;
    logic            cont_q, cont_d, frame_err_q, frame_err_d, done_q, done_d;
    logic [15:0]     pass_q, pass_d, err_q, err_d;
    logic [TW-1:0]   to_q, to_d;
    tx_e             tx_state_q, tx_state_d;
    logic [SW-1:0]   tx_s_q, tx_s_d, rx_s_q, rx_s_d;
    logic [NW-1:0]   tx_n_q, tx_n_d, rx_n_q, rx_n_d;
    logic [DBIT-1:0] tx_b_q, tx_b_d, rx_b_q, rx_b_d, tx_byte, exp_byte;
    logic            tx_q, tx_d, tx_go, tx_done;
    rx_e             rx_state_q, rx_state_d;
    logic            rx_meta_q, rx_sync_q, rx_begin, rx_done, next_txn;

    assign tick     = (baud_q == BW'(DVSR - 1));
    assign tx_done  = (tx_state_q == T_STOP) && tick && (tx_s_q == SW'(SB_TICK - 1));
    assign rx_done  = (rx_state_q == R_STOP) && tick && (rx_s_q == SW'(SB_TICK - 1));
    assign rx_begin = (ctrl_q == C_WAIT) && (rx_state_q == R_IDLE) && !rx_sync_q;
    assign exp_byte = last_sent_q + DBIT'(1);

    // Free-running 16x baud tick generator.
    always_comb begin
        baud_d = tick ? '0 : baud_q + BW'(1);
    end

    // Controller: sequences send, wait-for-reply, check and the next byte.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        ctrl_d      = ctrl_q;
        send_d      = send_q;
        cont_d      = cont_q;
        last_sent_d = last_sent_q;
        last_rcvd_d = last_rcvd_q;
        pass_d      = pass_q;
        err_d       = err_q;
        to_d        = to_q;
        frame_err_d = frame_err_q;
        done_d      = 1'b0;
        next_txn    = 1'b0;
        tx_go       = 1'b0;
        case (ctrl_q)
            C_IDLE: if (host.start) begin
                send_d = host.seed;
                cont_d = host.cont;
                ctrl_d = C_SEND;
                tx_go  = 1'b1;
            end
            C_SEND: if (tx_done) begin
                last_sent_d = send_q;
                to_d        = '0;
                ctrl_d      = C_WAIT;
            end
            C_WAIT: begin
                if (rx_done) begin
                    last_rcvd_d = rx_b_q;
                    frame_err_d = ~rx_sync_q;
                    ctrl_d      = C_CHECK;
                end else if (tick) begin
                    if (to_q != TW'(TIMEOUT_BT - 1)) begin
                        to_d = to_q + TW'(1);
                    end else if (rx_state_q == R_IDLE && !rx_begin) begin
                        // Timeout only while no reply frame is in progress.
                        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                        done_d   = 1'b1;
                        next_txn = 1'b1;
                    end
                end
            end
            C_CHECK: begin
                done_d   = 1'b1;
                next_txn = 1'b1;
                if (last_rcvd_q == exp_byte && !frame_err_q) begin
                    if (pass_q != 16'hFFFF) pass_d = pass_q + 16'd1;
                end else begin
                    if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                end
            end
            default: ctrl_d = C_IDLE;
        endcase
        if (next_txn) begin
            if (cont_q) begin
                send_d = send_q + DBIT'(1);
                ctrl_d = C_SEND;
                tx_go  = 1'b1;
            end else begin
                ctrl_d = C_IDLE;
            end
        end
        tx_byte = send_d;
`ifdef UART_LBCHK_INJECT_EN
        if (host.inject_err) tx_byte[0] = ~send_d[0];
`endif
    end

    // TX engine: start bit, DBIT data bits LSB first, stop bit; line follows next state.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_s_d     = tx_s_q;
        tx_n_d     = tx_n_q;
        tx_b_d     = tx_b_q;
        case (tx_state_q)
            T_IDLE: if (tx_go) begin
                tx_state_d = T_START;
                tx_s_d     = '0;
                tx_b_d     = tx_byte;
            end
            T_START: if (tick) begin
                if (tx_s_q == SW'(15)) begin
                    tx_state_d = T_DATA;
                    tx_s_d     = '0;
                    tx_n_d     = '0;
                end else tx_s_d = tx_s_q + SW'(1);
            end
            T_DATA: if (tick) begin
                if (tx_s_q == SW'(15)) begin
                    tx_s_d = '0;
                    tx_b_d = tx_b_q >> 1;
                    if (tx_n_q == NW'(DBIT - 1)) tx_state_d = T_STOP;
                    else                         tx_n_d     = tx_n_q + NW'(1);
                end else tx_s_d = tx_s_q + SW'(1);
            end
            T_STOP: if (tick) begin
                if (tx_s_q == SW'(SB_TICK - 1)) tx_state_d = T_IDLE;
                else                            tx_s_d     = tx_s_q + SW'(1);
            end
            default: tx_state_d = T_IDLE;
        endcase
        case (tx_state_d)
            T_START: tx_d = 1'b0;
            T_DATA:  tx_d = tx_b_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // RX engine: mid-bit sampling; a start bit gone high by mid-bit is a glitch.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_s_d     = rx_s_q;
        rx_n_d     = rx_n_q;
        rx_b_d     = rx_b_q;
        case (rx_state_q)
            R_IDLE: if (rx_begin) begin
                rx_state_d = R_START;
                rx_s_d     = '0;
            end
            R_START: if (tick) begin
                if (rx_s_q == SW'(7)) begin
                    rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
                    rx_s_d     = '0;
                    rx_n_d     = '0;
                end else rx_s_d = rx_s_q + SW'(1);
            end
            R_DATA: if (tick) begin
                if (rx_s_q == SW'(15)) begin
                    rx_s_d = '0;
                    rx_b_d = {rx_sync_q, rx_b_q[DBIT-1:1]};
                    if (rx_n_q == NW'(DBIT - 1)) rx_state_d = R_STOP;
                    else                         rx_n_d     = rx_n_q + NW'(1);
                end else rx_s_d = rx_s_q + SW'(1);
            end
            R_STOP: if (tick) begin
                if (rx_s_q == SW'(SB_TICK - 1)) rx_state_d = R_IDLE;
                else                            rx_s_d     = rx_s_q + SW'(1);
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    // State registers, with a two-flop synchroniser on the asynchronous rx line.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge (synchronous), so it lives inside the clocked branch.
        if (!reset) begin
            baud_q      <= '0;
            ctrl_q      <= C_IDLE;
            send_q      <= '0;
            cont_q      <= 1'b0;
            last_sent_q <= '0;
            last_rcvd_q <= '0;
            pass_q      <= '0;
            err_q       <= '0;
            to_q        <= '0;
            frame_err_q <= 1'b0;
            done_q      <= 1'b0;
            tx_state_q  <= T_IDLE;
            tx_s_q      <= '0;
            tx_n_q      <= '0;
            tx_b_q      <= '0;
            tx_q        <= 1'b1;
            rx_state_q  <= R_IDLE;
            rx_s_q      <= '0;
            rx_n_q      <= '0;
            rx_b_q      <= '0;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            baud_q      <= baud_d;
            ctrl_q      <= ctrl_d;
            send_q      <= send_d;
            cont_q      <= cont_d;
            last_sent_q <= last_sent_d;
            last_rcvd_q <= last_rcvd_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            to_q        <= to_d;
            frame_err_q <= frame_err_d;
            done_q      <= done_d;
            tx_state_q  <= tx_state_d;
            tx_s_q      <= tx_s_d;
            tx_n_q      <= tx_n_d;
            tx_b_q      <= tx_b_d;
            tx_q        <= tx_d;
            rx_state_q  <= rx_state_d;
            rx_s_q      <= rx_s_d;
            rx_n_q      <= rx_n_d;
            rx_b_q      <= rx_b_d;
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
        end
    end

    assign tx             = tx_q;
    assign host.busy      = (ctrl_q != C_IDLE);
    assign host.done_tick = done_q;
    assign host.last_sent = last_sent_q;
    assign host.last_rcvd = last_rcvd_q;
    assign host.pass_cnt  = pass_q;
    assign host.err_cnt   = err_q;
endmodule

// File: tb/tb_uart_loopback_checker.sv
`timescale 1ns/1ps
// tb_uart_loopback_checker
// Drives the checker against a behavioural far end that decodes the checker's
// tx frames and answers on rx (echo+1, silent, fixed byte or bad stop bit).
// Expected completions go into a scoreboard queue; a monitor pops and compares
// on every done_tick.
module tb_uart_loopback_checker;
    localparam int DBIT       = 8;
    localparam int SB_TICK    = 16;
    localparam int DVSR       = 2;
    localparam int TIMEOUT_BT = 64;
    localparam int BIT_CYC    = 16 * DVSR;

    typedef enum {M_ECHO, M_SILENT, M_FIXED, M_BADSTOP} mode_e;
    typedef struct {
        logic [7:0]  sent;
        logic [7:0]  rcvd;
        logic [15:0] pass;
        logic [15:0] err;
        logic        busy;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic tx;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_cyc = 0;

    mode_e      mode        = M_ECHO;
    logic [7:0] fixed_val   = 8'h00;
    bit         ignore_wire = 1'b0;
    logic [7:0] exp_wire_q[$];
    exp_t       exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_loopback_checker_if #(.DBIT(DBIT)) bus ();

    uart_loopback_checker #(
        .DBIT(DBIT), .SB_TICK(SB_TICK), .DVSR(DVSR), .TIMEOUT_BT(TIMEOUT_BT)
    ) dut (
        .clk(clk), .reset(rst_n), .rx(rx), .tx(tx), .host(bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < DBIT; i++) begin
            rx = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        rx = stop_val;
        repeat (BIT_CYC) @(negedge clk);
        rx = 1'b1;
    endtask

    // Far end: decode each tx frame at mid-bit, check it, then answer per mode.
    initial begin : far_end
        logic [7:0] b;
        logic [7:0] reply;
        logic       stop_seen;
        logic       stop_val;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (BIT_CYC / 2) @(negedge clk);
                if (tx === 1'b0) begin
                    for (int i = 0; i < DBIT; i++) begin
                        repeat (BIT_CYC) @(negedge clk);
                        b[i] = tx;
                    end
                    repeat (BIT_CYC) @(negedge clk);
                    stop_seen = tx;
                    if (!ignore_wire) begin
                        if (exp_wire_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL wire_unexpected: got byte 0x%02h, none expected", b);
                        end else begin
                            check("wire_byte", b, exp_wire_q.pop_front());
                        end
                        check("wire_stop", stop_seen, 1);
                    end
                    if (mode != M_SILENT) begin
                        reply    = (mode == M_FIXED) ? fixed_val : b + 8'd1;
                        stop_val = (mode != M_BADSTOP);
                        fork
                            begin
                                automatic logic [7:0] r = reply;
                                automatic logic       s = stop_val;
                                repeat (40) @(negedge clk);
                                send_frame(r, s);
                            end
                        join_none
                    end
                end
            end
        end
    end

    // Monitor: every done_tick must match the oldest expected completion.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done_tick === 1'b1) begin
                done_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL done_unexpected: done_tick with no completion expected at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("done_last_sent", bus.last_sent, e.sent);
                    check("done_last_rcvd", bus.last_rcvd, e.rcvd);
                    check("done_pass_cnt",  bus.pass_cnt,  e.pass);
                    check("done_err_cnt",   bus.err_cnt,   e.err);
                    check("done_busy",      bus.busy,      e.busy);
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [7:0] sent, input logic [7:0] rcvd,
                            input logic [15:0] pass, input logic [15:0] err, input logic busy);
        exp_t e;
        e.sent = sent; e.rcvd = rcvd; e.pass = pass; e.err = err; e.busy = busy;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start(input logic [7:0] seed, input logic cont);
        @(negedge clk);
        bus.seed  = seed;
        bus.cont  = cont;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input bit need_idle);
        int n = 0;
        while ((exp_q.size() != 0 || (need_idle && bus.busy === 1'b1)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_within_budget", (exp_q.size() == 0) && !(need_idle && bus.busy === 1'b1), 1);
        if (need_idle) repeat (64) @(negedge clk);
    endtask

    initial begin : stim
        int st;
        bus.start = 1'b0;
        bus.cont  = 1'b0;
        bus.seed  = '0;
`ifdef UART_LBCHK_INJECT_EN
        bus.inject_err = 1'b0;
`endif
        do_reset();
        check("rst_tx",        tx,            1);
        check("rst_busy",      bus.busy,      0);
        check("rst_done",      bus.done_tick, 0);
        check("rst_last_sent", bus.last_sent, 0);
        check("rst_last_rcvd", bus.last_rcvd, 0);
        check("rst_pass",      bus.pass_cnt,  0);
        check("rst_err",       bus.err_cnt,   0);

        // Single echo transaction.
        mode = M_ECHO;
        exp_wire_q.push_back(8'h41);
        push_exp(8'h41, 8'h42, 16'd1, 16'd0, 1'b0);
        pulse_start(8'h41, 1'b0);
        check("busy_after_start", bus.busy, 1);
        wait_drain(2000, 1'b1);

        // Wrap: FF expects 00.
        do_reset();
        exp_wire_q.push_back(8'hFF);
        push_exp(8'hFF, 8'h00, 16'd1, 16'd0, 1'b0);
        pulse_start(8'hFF, 1'b0);
        wait_drain(2000, 1'b1);

        // Silent far end: timeout 64 baud ticks after the stop bit.
        do_reset();
        mode = M_SILENT;
        exp_wire_q.push_back(8'h33);
        push_exp(8'h33, 8'h00, 16'd0, 16'd1, 1'b0);
        st = cyc;
        pulse_start(8'h33, 1'b0);
        wait_drain(2000, 1'b1);
        check("timeout_latency_in_window", (done_cyc - st >= 440) && (done_cyc - st <= 460), 1);

        // Wrong reply, then correct data with a bad stop bit.
        do_reset();
        mode = M_FIXED;
        fixed_val = 8'h10;
        exp_wire_q.push_back(8'h20);
        push_exp(8'h20, 8'h10, 16'd0, 16'd1, 1'b0);
        pulse_start(8'h20, 1'b0);
        wait_drain(2000, 1'b1);
        mode = M_BADSTOP;
        exp_wire_q.push_back(8'h20);
        push_exp(8'h20, 8'h21, 16'd0, 16'd2, 1'b0);
        pulse_start(8'h20, 1'b0);
        wait_drain(2000, 1'b1);

        // Continuous run from FE, then reset in the middle of the fourth frame.
        do_reset();
        mode = M_ECHO;
        exp_wire_q.push_back(8'hFE);
        exp_wire_q.push_back(8'hFF);
        exp_wire_q.push_back(8'h00);
        push_exp(8'hFE, 8'hFF, 16'd1, 16'd0, 1'b1);
        push_exp(8'hFF, 8'h00, 16'd2, 16'd0, 1'b1);
        push_exp(8'h00, 8'h01, 16'd3, 16'd0, 1'b1);
        pulse_start(8'hFE, 1'b1);
        wait_drain(5000, 1'b0);
        mode        = M_SILENT;
        ignore_wire = 1'b1;
        repeat (110) @(negedge clk);
        check("tx_low_mid_data_bit", tx, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_tx",        tx,            1);
        check("midreset_busy",      bus.busy,      0);
        check("midreset_pass",      bus.pass_cnt,  0);
        check("midreset_err",       bus.err_cnt,   0);
        check("midreset_last_rcvd", bus.last_rcvd, 0);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        check("tx_idle_after_abort", tx, 1);
        ignore_wire = 1'b0;
        mode        = M_ECHO;

`ifdef UART_LBCHK_INJECT_EN
        // Injected bit-0 error: wire carries 05, echo 06 fails against 04+1.
        do_reset();
        bus.inject_err = 1'b1;
        exp_wire_q.push_back(8'h05);
        push_exp(8'h04, 8'h06, 16'd0, 16'd1, 1'b0);
        pulse_start(8'h04, 1'b0);
        bus.inject_err = 1'b0;
        wait_drain(2000, 1'b1);
`endif

        check("wire_queue_empty", exp_wire_q.size(), 0);
        check("exp_queue_empty",  exp_q.size(),      0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
